// File: rtl/mem_arb_ctrl.sv
// mem_arb_ctrl
// Shares a single 64x8 synchronous memory (single address, rd_en/wr_en,
// registered read data) between two requesters, port A and port B.
//
// Handshake: a request transfers on any cycle where x_valid && x_ready.
// x_ready is combinational. It is high only in IDLE, only while x_valid is
// high, and only when x wins arbitration. Requesters hold
// valid/we/addr/wdata stable until they see ready.
//
// Timing for a request accepted at edge T:
//   cycle T+1 (ACCESS): exactly one of mem_wr_en / mem_rd_en is high.
//   cycle T+2 (RESP, reads only): x_rvalid pulses and x_rdata shows the word.
// Round-robin pointer: with both ports valid, the pointer picks the winner.
// After every accept the pointer moves to the other port.
//
// Optional feature, macro MEM_ARB_STATS_EN: adds saturating per-port grant
// counters a_grants/b_grants (STAT_W bits) and a synchronous clear input,
// stats_clr.
//
// Ports:
//   wb_clk_i, wb_rst_i      clock, synchronous active-high reset
//   a_* / b_*               requester ports (valid, we, addr, wdata, ready,
//                           rvalid, rdata)
//   mem_addr/mem_wdata/mem_wr_en/mem_rd_en/mem_rdata   memory interface
//   busy                    high whenever the FSM is not in IDLE
//   state_dbg               current FSM state (0 IDLE, 1 ACCESS, 2 RESP)
//   a_grants/b_grants/stats_clr  only with MEM_ARB_STATS_EN
module mem_arb_ctrl #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int STAT_W = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              a_valid,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ready,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_valid,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ready,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef MEM_ARB_STATS_EN
  input  logic              stats_clr,
  output logic [STAT_W-1:0] a_grants,
  output logic [STAT_W-1:0] b_grants,
`endif
  output logic              busy,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              ptr_q, ptr_d;       // 0: A has priority, 1: B has priority
  logic              owner_q, owner_d;   // 0: A owns the access, 1: B
  logic              we_q, we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_wr_en_q, mem_wr_en_d;
  logic              mem_rd_en_q, mem_rd_en_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

  logic is_idle;
  logic grant_a;
  logic grant_b;
  logic resp_a;
  logic resp_b;

  assign is_idle = (state_q == S_IDLE);
  assign grant_a = is_idle && a_valid && (!b_valid || !ptr_q);
  assign grant_b = is_idle && b_valid && (!a_valid ||  ptr_q);

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // The memory's registered read data is only valid during RESP, so the
  // response pulse is shown straight from mem_rdata. The same word is kept
  // in x_rdata_q for the cycles that follow. Reset suppresses a pulse that
  // is still in flight.
  assign resp_a = (state_q == S_RESP) && !owner_q && !wb_rst_i;
  assign resp_b = (state_q == S_RESP) &&  owner_q && !wb_rst_i;

  assign a_rvalid = resp_a;
  assign b_rvalid = resp_b;
  assign a_rdata  = resp_a ? mem_rdata : a_rdata_q;
  assign b_rdata  = resp_b ? mem_rdata : b_rdata_q;

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wr_en = mem_wr_en_q;
  assign mem_rd_en = mem_rd_en_q;
  assign busy      = !is_idle;
  assign state_dbg = state_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    we_d        = we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wr_en_d = 1'b0;
    mem_rd_en_d = 1'b0;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (grant_a || grant_b) begin
          owner_d     = grant_b;
          we_d        = grant_b ? b_we    : a_we;
          mem_addr_d  = grant_b ? b_addr  : a_addr;
          mem_wdata_d = grant_b ? b_wdata : a_wdata;
          mem_wr_en_d = grant_b ? b_we    : a_we;
          mem_rd_en_d = grant_b ? !b_we   : !a_we;
          ptr_d       = !grant_b;   // priority moves to the port that lost
          state_d     = S_ACCESS;
        end
      end
      S_ACCESS: begin
        state_d = we_q ? S_IDLE : S_RESP;
      end
      S_RESP: begin
        if (owner_q) begin
          b_rdata_d = mem_rdata;
        end else begin
          a_rdata_d = mem_rdata;
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      ptr_q       <= 1'b0;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wr_en_q <= 1'b0;
      mem_rd_en_q <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wr_en_q <= mem_wr_en_d;
      mem_rd_en_q <= mem_rd_en_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic [STAT_W-1:0] a_grants_q, a_grants_d;
  logic [STAT_W-1:0] b_grants_q, b_grants_d;

  // A clear that coincides with an accept leaves that port's counter at 1.
  always_comb begin
    a_grants_d = stats_clr ? '0 : a_grants_q;
    b_grants_d = stats_clr ? '0 : b_grants_q;
    if (grant_a && (a_grants_d != '1)) begin
      a_grants_d = a_grants_d + STAT_W'(1);
    end
    if (grant_b && (b_grants_d != '1)) begin
      b_grants_d = b_grants_d + STAT_W'(1);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      a_grants_q <= '0;
      b_grants_q <= '0;
    end else begin
      a_grants_q <= a_grants_d;
      b_grants_q <= b_grants_d;
    end
  end

  assign a_grants = a_grants_q;
  assign b_grants = b_grants_q;
`else
  // Grant counters are not built. This empty block only keeps STAT_W
  // referenced in this configuration.
  if (STAT_W < 1) begin : g_no_stats
  end
`endif

endmodule

// File: tb/tb_mem_arb_ctrl.sv
module tb_mem_arb_ctrl;

`ifdef MEM_ARB_STATS_EN
  localparam int TB_STAT_W = 2;
`else
  localparam int TB_STAT_W = 16;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_valid = 1'b0, a_we = 1'b0;
  logic [5:0] a_addr = '0;
  logic [7:0] a_wdata = '0;
  logic       a_ready, a_rvalid;
  logic [7:0] a_rdata;
  logic       b_valid = 1'b0, b_we = 1'b0;
  logic [5:0] b_addr = '0;
  logic [7:0] b_wdata = '0;
  logic       b_ready, b_rvalid;
  logic [7:0] b_rdata;
  logic [5:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_wr_en, mem_rd_en;
  logic [7:0] mem_rdata;
  logic       busy;
  logic [1:0] state_dbg;
`ifdef MEM_ARB_STATS_EN
  logic                 stats_clr = 1'b0;
  logic [TB_STAT_W-1:0] a_grants, b_grants;
`endif

  mem_arb_ctrl #(.ADDR_W(6), .DATA_W(8), .STAT_W(TB_STAT_W)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .a_valid  (a_valid),
    .a_we     (a_we),
    .a_addr   (a_addr),
    .a_wdata  (a_wdata),
    .a_ready  (a_ready),
    .a_rvalid (a_rvalid),
    .a_rdata  (a_rdata),
    .b_valid  (b_valid),
    .b_we     (b_we),
    .b_addr   (b_addr),
    .b_wdata  (b_wdata),
    .b_ready  (b_ready),
    .b_rvalid (b_rvalid),
    .b_rdata  (b_rdata),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wr_en(mem_wr_en),
    .mem_rd_en(mem_rd_en),
    .mem_rdata(mem_rdata),
`ifdef MEM_ARB_STATS_EN
    .stats_clr(stats_clr),
    .a_grants (a_grants),
    .b_grants (b_grants),
`endif
    .busy     (busy),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory model (64x8, registered read) ----------------
  logic [7:0] tb_mem [64];
  always @(posedge clk) begin
    if (mem_wr_en) tb_mem[mem_addr] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= tb_mem[mem_addr];
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard / monitors ----------------
  logic [7:0] exp_a_q[$];
  logic [7:0] exp_b_q[$];
  bit         grant_log[$];   // 0 = A accepted, 1 = B accepted
  int         en_both_cnt = 0;
  int         en_outside_cnt = 0;

  // Samples 3 time units after the falling edge: inputs have settled and
  // the next rising edge has not yet arrived.
  always begin
    @(negedge clk);
    #3;
    if (!rst) begin
      if (a_ready) grant_log.push_back(1'b0);
      if (b_ready) grant_log.push_back(1'b1);
      if (a_ready && b_ready) check("both_ready", 1, 0);
    end
    if (mem_wr_en && mem_rd_en) en_both_cnt++;
    if ((mem_wr_en || mem_rd_en) && state_dbg != 2'd1) en_outside_cnt++;
    if (a_rvalid) begin
      if (exp_a_q.size() == 0) check("a_rvalid_unexpected", 1, 0);
      else check("a_rdata_sb", {24'h0, a_rdata}, {24'h0, exp_a_q.pop_front()});
    end
    if (b_rvalid) begin
      if (exp_b_q.size() == 0) check("b_rvalid_unexpected", 1, 0);
      else check("b_rdata_sb", {24'h0, b_rdata}, {24'h0, exp_b_q.pop_front()});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Presents one request and returns at negedge+1 of the ACCESS cycle
  // (one cycle after the accept edge). acc_cyc is the accept cycle number.
  task automatic req(input bit port, input logic we, input logic [5:0] addr,
                     input logic [7:0] wd, output int acc_cyc);
    bit done;
    done = 1'b0;
    acc_cyc = -1;
    if (!port) begin a_valid = 1'b1; a_we = we; a_addr = addr; a_wdata = wd; end
    else       begin b_valid = 1'b1; b_we = we; b_addr = addr; b_wdata = wd; end
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (port ? b_ready : a_ready) begin
        done = 1'b1;
        acc_cyc = cyc;
      end
      @(negedge clk);
      #1;
    end
    if (!port) a_valid = 1'b0; else b_valid = 1'b0;
    if (!done) check("req_timeout", 1, 0);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_mem_wr_en"}, mem_wr_en, 0);
    check({pfx, "_mem_rd_en"}, mem_rd_en, 0);
    check({pfx, "_mem_addr"},  mem_addr,  0);
    check({pfx, "_mem_wdata"}, mem_wdata, 0);
    check({pfx, "_a_rvalid"},  a_rvalid,  0);
    check({pfx, "_b_rvalid"},  b_rvalid,  0);
    check({pfx, "_a_rdata"},   a_rdata,   0);
    check({pfx, "_b_rdata"},   b_rdata,   0);
    check({pfx, "_busy"},      busy,      0);
    check({pfx, "_state"},     state_dbg, 0);
  endtask

  // ---------------- directed stimulus ----------------
  int c0, c1, c2, c3;

  initial begin
    do_reset();
    check_reset_outputs("rst");

    // 1) A writes 5 = 0x3C, then A reads it back.
    req(1'b0, 1'b1, 6'd5, 8'h3C, c0);
    check("t1_wr_en",  mem_wr_en, 1);
    check("t1_rd_en",  mem_rd_en, 0);
    check("t1_addr",   mem_addr,  5);
    check("t1_wdata",  mem_wdata, 8'h3C);
    check("t1_busy",   busy,      1);
    tick();
    check("t1_wr_en_off", mem_wr_en, 0);
    check("t1_idle",      busy,      0);
    exp_a_q.push_back(8'h3C);
    req(1'b0, 1'b0, 6'd5, 8'h00, c0);
    check("t1_rd_en",  mem_rd_en, 1);
    check("t1_rvalid_early", a_rvalid, 0);
    tick();
    check("t1_a_rvalid", a_rvalid, 1);
    check("t1_a_rdata",  a_rdata,  8'h3C);
    check("t1_b_rvalid", b_rvalid, 0);
    tick();
    check("t1_a_rvalid_off", a_rvalid, 0);
    check("t1_a_rdata_hold", a_rdata,  8'h3C);

    // 2) Preload 1 = 0x11, 2 = 0x22, then reset and contend with reads.
    req(1'b0, 1'b1, 6'd1, 8'h11, c0);
    req(1'b1, 1'b1, 6'd2, 8'h22, c0);
    tick();
    do_reset();
    grant_log.delete();
    exp_a_q.push_back(8'h11); exp_a_q.push_back(8'h11);
    exp_b_q.push_back(8'h22); exp_b_q.push_back(8'h22);
    a_valid = 1'b1; a_we = 1'b0; a_addr = 6'd1;
    b_valid = 1'b1; b_we = 1'b0; b_addr = 6'd2;
    for (int i = 0; i < 40 && grant_log.size() < 4; i++) tick();
    a_valid = 1'b0;
    b_valid = 1'b0;
    check("t2_grant_cnt", grant_log.size(), 4);
    if (grant_log.size() >= 4) begin
      check("t2_grant0", grant_log[0], 0);
      check("t2_grant1", grant_log[1], 1);
      check("t2_grant2", grant_log[2], 0);
      check("t2_grant3", grant_log[3], 1);
    end
    repeat (3) tick();
    check("t2_a_rdata", a_rdata, 8'h11);
    check("t2_b_rdata", b_rdata, 8'h22);

    // 3) Only B: four writes back to back, accepted every two cycles.
    req(1'b1, 1'b1, 6'd10, 8'hA0, c0);
    req(1'b1, 1'b1, 6'd11, 8'hA1, c1);
    req(1'b1, 1'b1, 6'd12, 8'hA2, c2);
    req(1'b1, 1'b1, 6'd13, 8'hA3, c3);
    check("t3_gap1", c1 - c0, 2);
    check("t3_gap2", c2 - c1, 2);
    check("t3_gap3", c3 - c2, 2);
    tick();
    check("t3_mem10", tb_mem[10], 8'hA0);
    check("t3_mem13", tb_mem[13], 8'hA3);

    // 4) Boundary addresses: B writes 63 and 0, A reads both.
    req(1'b1, 1'b1, 6'd63, 8'hFF, c0);
    check("t4_addr63", mem_addr, 63);
    req(1'b1, 1'b1, 6'd0, 8'h01, c0);
    check("t4_addr0", mem_addr, 0);
    exp_a_q.push_back(8'hFF);
    req(1'b0, 1'b0, 6'd63, 8'h00, c0);
    tick();
    check("t4_rvalid63", a_rvalid, 1);
    check("t4_rdata63",  a_rdata,  8'hFF);
    exp_a_q.push_back(8'h01);
    req(1'b0, 1'b0, 6'd0, 8'h00, c0);
    tick();
    check("t4_rvalid0", a_rvalid, 1);
    check("t4_rdata0",  a_rdata,  8'h01);
    check("t4_b_rvalid", b_rvalid, 0);

    // 5) Reset during RESP of an A read: no pulse, outputs cleared, A first.
    req(1'b0, 1'b0, 6'd5, 8'h00, c0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    check("t5_no_rvalid", a_rvalid, 0);
    tick();
    check_reset_outputs("t5");
    rst = 1'b0;
    grant_log.delete();
    a_valid = 1'b1; a_we = 1'b1; a_addr = 6'd20; a_wdata = 8'h20;
    b_valid = 1'b1; b_we = 1'b1; b_addr = 6'd21; b_wdata = 8'h21;
    for (int i = 0; i < 20 && grant_log.size() < 2; i++) tick();
    a_valid = 1'b0;
    b_valid = 1'b0;
    check("t5_grant_cnt", grant_log.size(), 2);
    if (grant_log.size() >= 2) begin
      check("t5_first_a",  grant_log[0], 0);
      check("t5_second_b", grant_log[1], 1);
    end
    repeat (2) tick();

`ifdef MEM_ARB_STATS_EN
    // 6) Grant counters (STAT_W = 2 here): count, clear, saturate, clr+accept.
    do_reset();
    check("s_rst_a", a_grants, 0);
    check("s_rst_b", b_grants, 0);
    repeat (3) req(1'b0, 1'b1, 6'd30, 8'h30, c0);
    repeat (2) req(1'b1, 1'b1, 6'd31, 8'h31, c0);
    check("s_a3", a_grants, 3);
    check("s_b2", b_grants, 2);
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    tick();
    check("s_clr_a", a_grants, 0);
    check("s_clr_b", b_grants, 0);
    repeat (4) req(1'b0, 1'b1, 6'd32, 8'h32, c0);
    check("s_sat_a", a_grants, 3);
    stats_clr = 1'b1;
    req(1'b1, 1'b1, 6'd33, 8'h33, c0);
    stats_clr = 1'b0;
    check("s_clracc_b", b_grants, 1);
    check("s_clracc_a", a_grants, 0);
    tick();
`endif

    check("en_both_never",  en_both_cnt,    0);
    check("en_outside_acc", en_outside_cnt, 0);
    check("exp_a_empty", exp_a_q.size(), 0);
    check("exp_b_empty", exp_b_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_arb_ctrl.md
Name: mem_arb_ctrl

Overview:
- Two-requester controller/arbiter that shares one 64x8 synchronous memory block (mem_block-style: single addr, rd_en/wr_en, registered rout_data) between port A (Wishbone-side master) and port B (IO-pad-side master).
- Performs round-robin arbitration, a valid/ready request handshake, and memory access sequencing.
- Returns read data with an rvalid pulse.
- Sits between the user-project top level and the memory instance; it is the only driver of the memory control pins.

Parameters:
- ADDR_W, 6, memory address width (64 words).
- DATA_W, 8, memory data width.
- STAT_W, 16, width of grant counters (used only with the optional feature).

Ports:
- wb_clk_i  in  1  clock; all logic on posedge.
- wb_rst_i  in  1  synchronous active-high reset.
- a_valid  in  1  port A request valid.
- a_we  in  1  port A: 1 = write, 0 = read.
- a_addr  in  ADDR_W  port A address.
- a_wdata  in  DATA_W  port A write data.
- a_ready  out  1  port A request accepted this cycle.
- a_rvalid  out  1  port A read data valid, one-cycle pulse.
- a_rdata  out  DATA_W  port A read data.
- b_valid, b_we, b_addr, b_wdata, b_ready, b_rvalid, b_rdata  (same as port A, for port B).
- mem_addr  out  ADDR_W  to memory addr.
- mem_wdata  out  DATA_W  to memory wdata.
- mem_wr_en  out  1  to memory wr_en.
- mem_rd_en  out  1  to memory rd_en.
- mem_rdata  in  DATA_W  from memory rout_data (registered inside memory).
- busy  out  1  high whenever state != IDLE.

Behaviour:
- States: IDLE, ACCESS, RESP. Reset -> IDLE.
- Reset values: mem_wr_en = 0, mem_rd_en = 0, mem_addr = 0, mem_wdata = 0, a_rvalid = 0, b_rvalid = 0, a_rdata = 0, b_rdata = 0, busy = 0, priority pointer = A.
- Handshake:
  - x_ready is combinational and asserts only in IDLE with x_valid high, and x wins arbitration.
  - A request transfers on a cycle where x_valid && x_ready.
  - Requesters hold valid/we/addr/wdata stable until ready.
- Arbitration in IDLE:
  - Only one requester valid -> that one wins.
  - Both valid -> the one indicated by the pointer wins.
  - After every accepted request, the pointer moves to the other port (strict alternation under contention).
- On accept (edge T): latch owner, we, addr, wdata into mem_* registers; state <= ACCESS.
- ACCESS (cycle T+1): exactly one of mem_wr_en/mem_rd_en is high for exactly one cycle.
  - Write -> next state IDLE (write complete at edge ending T+1).
  - Read -> next state RESP.
- RESP (cycle T+2):
  - Capture mem_rdata into owner's x_rdata; owner's x_rvalid = 1 for exactly this cycle. Other port's rvalid stays 0.
  - Next state IDLE.
  - x_rdata holds its value until the next read completion for that port.
- Latency: write accept -> memory updated 1 cycle later; read accept -> rvalid 2 cycles later.
- Throughput: writes 1 per 2 cycles, reads 1 per 3 cycles. No new accept while busy.
- Invariants:
  - mem_wr_en and mem_rd_en are never high simultaneously.
  - Both enables are low outside ACCESS; mem_addr/mem_wdata hold their last values.
- Boundaries:
  - Address 0 and 63 are both legal; no wrap or range logic is needed.
  - Read of a never-written word returns whatever the memory returns (X in simulation is acceptable).
- Reset asserted mid-operation (ACCESS or RESP): next edge forces IDLE with all outputs at reset values. No pending rvalid is issued, and the pointer returns to A. A write in ACCESS during the reset cycle may or may not commit; the bench does not check it.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- Defined:
  - Adds outputs a_grants and b_grants (STAT_W bits each), cleared by wb_rst_i.
  - Each increments by 1 on every accepted request of its port, saturating at all-ones (no wrap).
  - Adds input stats_clr (1 bit): synchronous clear of both counters. If clr and an accept coincide, the counter becomes 1 for the accepting port.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- A writes addr 5 = 0x3C, then A reads addr 5 -> mem_wr_en 1 cycle after accept; a_rvalid exactly 2 cycles after read accept with a_rdata = 0x3C; b_rvalid stays 0.
- A and B both valid continuously after reset, A: read addr 1, B: read addr 2 (pre-loaded 0x11/0x22) -> grants alternate A,B,A,B; first a_rdata = 0x11, first b_rdata = 0x22.
- Only B valid for 4 requests -> B accepted every idle slot (every 2 cycles for writes); pointer irrelevant.
- B writes addr 63 = 0xFF and addr 0 = 0x01; A reads both -> 0xFF and 0x01; check mem_wr_en and mem_rd_en never both high across the whole run.
- Assert wb_rst_i during RESP of an A read -> no a_rvalid pulse; all outputs 0 next cycle; with both valid afterwards, A is granted first.
- MEM_ARB_STATS_EN: 3 A accepts, 2 B accepts -> a_grants = 3, b_grants = 2. Pulse stats_clr -> both 0. Force saturation with STAT_W = 2 -> the counter holds at 3.
